// File: rtl/im_pkg.sv
// im_pkg: shared defaults and types for the instruction fetch memory.
// Holds the default geometry (word width, address width, words per fetch,
// read latency), the fetch-bundle typedef and a byte-enable width helper.
package im_pkg;

   localparam int IM_DATA_W  = 32;
   localparam int IM_ADDR_W  = 10;
   localparam int IM_FETCH_N = 2;
   localparam int IM_RD_LAT  = 1;

   typedef logic [IM_DATA_W-1:0] im_word_t;

   // One fetch: IM_FETCH_N consecutive words, word k in element k.
   typedef im_word_t [IM_FETCH_N-1:0] im_fetch_t;

   // Number of byte lanes in a word of the given width.
   function automatic int im_be_w(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/im_fetch_mem_if.sv
// im_fetch_mem_if: fetch request/response handshake plus program-load port.
// Ports: req_valid/req_ready/req_addr, rsp_valid/rsp_ready/rsp_data, flush,
//        ld_en/ld_addr/ld_data/ld_be. master = fetch unit + loader, slave = memory.
interface im_fetch_mem_if
   import im_pkg::*;
#(
   parameter int DATA_W  = IM_DATA_W,
   parameter int ADDR_W  = IM_ADDR_W,
   parameter int FETCH_N = IM_FETCH_N
);

   localparam int BE_W = im_be_w(DATA_W);

   logic                        req_valid;
   logic                        req_ready;
   logic [ADDR_W-1:0]           req_addr;
   logic                        rsp_valid;
   logic                        rsp_ready;
   logic [FETCH_N*DATA_W-1:0]   rsp_data;
   logic                        flush;
   logic                        ld_en;
   logic [ADDR_W-1:0]           ld_addr;
   logic [DATA_W-1:0]           ld_data;
   logic [BE_W-1:0]             ld_be;

   modport master (
      output req_valid, req_addr, rsp_ready, flush,
             ld_en, ld_addr, ld_data, ld_be,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready, flush,
             ld_en, ld_addr, ld_data, ld_be,
      output req_ready, rsp_valid, rsp_data
   );

endinterface

// File: rtl/im_bank.sv
// im_bank: word-addressed storage, one byte-enabled write port and FETCH_N
// read ports (combinational address, registered data, updated only when rd_en).
// Ports: clk, rst, wr_en/wr_addr/wr_data/wr_be, rd_en, rd_addr[k], rd_data[k].
module im_bank
   import im_pkg::*;
#(
   parameter int DATA_W       = IM_DATA_W,
   parameter int ADDR_W       = IM_ADDR_W,
   parameter int FETCH_N      = IM_FETCH_N,
   parameter bit CLEAR_ON_RST = 1'b1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              wr_en,
   input  logic [ADDR_W-1:0]                 wr_addr,
   input  logic [DATA_W-1:0]                 wr_data,
   input  logic [DATA_W/8-1:0]               wr_be,
   input  logic                              rd_en,
   input  logic [FETCH_N-1:0][ADDR_W-1:0]    rd_addr,
   output logic [FETCH_N-1:0][DATA_W-1:0]    rd_data
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int NB    = DATA_W / 8;

   logic [DATA_W-1:0] mem [DEPTH];

   generate
      if (CLEAR_ON_RST) begin : g_clear
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            end else if (wr_en) begin
               for (int b = 0; b < NB; b++)
                  if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
         end
      end else begin : g_keep
         // Contents survive reset: no reset term on the array.
         always_ff @(posedge clk) begin
            if (wr_en) begin
               for (int b = 0; b < NB; b++)
                  if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
         end
      end
   endgenerate

   // Reads sample the array before this edge's write lands, so a same-word
   // read and load return the old data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         for (int k = 0; k < FETCH_N; k++) rd_data[k] <= mem[rd_addr[k]];
      end
   end

endmodule

// File: rtl/im_fetch_mem.sv
// im_fetch_mem: instruction fetch memory returning FETCH_N consecutive words
// per request, RD_LAT cycles after acceptance (plus one cycle per stall).
// Backpressure: req_ready = !rsp_valid || rsp_ready; the whole pipe freezes
// while a response is held. Ports: clk, rst, bus (im_fetch_mem_if.slave).
module im_fetch_mem
   import im_pkg::*;
#(
   parameter int DATA_W       = IM_DATA_W,
   parameter int ADDR_W       = IM_ADDR_W,
   parameter int FETCH_N      = IM_FETCH_N,
   parameter int RD_LAT       = IM_RD_LAT,
   parameter bit CLEAR_ON_RST = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   im_fetch_mem_if.slave  bus
);

   logic                             advance;
   logic                             accept;
   logic                             rsp_valid;
   logic [RD_LAT-1:0]                vld_q;
   logic [FETCH_N-1:0][ADDR_W-1:0]   rd_addr;
   logic [FETCH_N-1:0][DATA_W-1:0]   bank_dat;
   logic [FETCH_N-1:0][DATA_W-1:0]   out_dat;

   assign rsp_valid     = vld_q[RD_LAT-1];
   assign advance       = !rsp_valid || bus.rsp_ready;
   assign accept        = bus.req_valid && advance;
   assign bus.req_ready = advance;

   // Word k of the fetch; the sum truncates to ADDR_W so the top word wraps to 0.
   always_comb begin
      rd_addr = '0;
      for (int k = 0; k < FETCH_N; k++) rd_addr[k] = bus.req_addr + ADDR_W'(k);
   end

   // The bank's output register is the first latency stage, so it only
   // captures on advance; otherwise it holds with the rest of the pipe.
   im_bank #(
      .DATA_W       (DATA_W),
      .ADDR_W       (ADDR_W),
      .FETCH_N      (FETCH_N),
      .CLEAR_ON_RST (CLEAR_ON_RST)
   ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (bus.ld_en),
      .wr_addr (bus.ld_addr),
      .wr_data (bus.ld_data),
      .wr_be   (bus.ld_be),
      .rd_en   (advance),
      .rd_addr (rd_addr),
      .rd_data (bank_dat)
   );

   // Stage valids; the last one is rsp_valid. Flush wins over advance so a
   // request accepted on the flush edge never enters the pipe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
      end else if (bus.flush) begin
         vld_q <= '0;
      end else if (advance) begin
         vld_q[0] <= accept;
         for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic [FETCH_N-1:0][DATA_W-1:0] dat_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst)          dat_q <= '0;
            else if (advance) dat_q <= bank_dat;
         end

         assign out_dat = dat_q;
      end else begin : g_lat1
         assign out_dat = bank_dat;
      end
   endgenerate

   // Stale stage data is masked so an idle response port always reads zero.
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_data  = rsp_valid ? out_dat : '0;

endmodule

// File: doc/im_fetch_mem.md
IM_FETCH_MEM -- requirements
Module: im_fetch_mem

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32: instruction word width in bits, a multiple of 8.
REQ-002 The block SHALL take parameter ADDR_W, default 10: word address width; depth = 2**ADDR_W words.
REQ-003 The block SHALL take parameter FETCH_N, default 2: consecutive words returned per request, legal range 1..4.
REQ-004 The block SHALL take parameter RD_LAT, default 1: request-to-response latency in cycles, legal values 1 or 2.
REQ-005 The block SHALL take parameter CLEAR_ON_RST, default 1: when 1, reset zeroes the memory array.
REQ-006 clk  input  1  clock; all logic is rising-edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 req_valid  input  1  fetch request present.
REQ-009 req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-010 req_addr  input  ADDR_W  word address of the first fetched word.
REQ-011 rsp_valid  output  1  rsp_data holds a valid fetch.
REQ-012 rsp_ready  input  1  consumer accepts the response.
REQ-013 rsp_data  output  FETCH_N*DATA_W  fetched words; word k in bits [k*DATA_W +: DATA_W].
REQ-014 flush  input  1  discard all in-flight and held responses.
REQ-015 ld_en  input  1  program-load write strobe.
REQ-016 ld_addr  input  ADDR_W  load word address.
REQ-017 ld_data  input  DATA_W  load data.
REQ-018 ld_be  input  DATA_W/8  byte enables for ld_data.

Function
REQ-019 A request SHALL be accepted on a clk edge where req_valid and req_ready are both high.
REQ-020 advance = !rsp_valid || rsp_ready; req_ready SHALL equal advance, combinationally.
REQ-021 When advance is high, all RD_LAT pipeline stages SHALL shift one step; when low, all stages and rsp_data SHALL hold unchanged.
REQ-022 An accepted request SHALL produce rsp_valid exactly RD_LAT cycles later when no stall occurs; each stall cycle adds one cycle.
REQ-023 Word k of rsp_data SHALL be mem[(req_addr + k) mod 2**ADDR_W]; addresses wrap from the top word to word 0.
REQ-024 When rsp_valid is low, rsp_data SHALL be all zeros.
REQ-025 On a cycle with ld_en high, each byte b with ld_be[b] high SHALL be written to mem[ld_addr]; bytes with ld_be[b] low SHALL be unchanged.
REQ-026 Loads SHALL be accepted every cycle, independent of req/rsp handshake state and of flush.
REQ-027 A read and a load to the same word in the same cycle SHALL return the pre-write data (read-before-write).
REQ-028 flush high on an edge SHALL clear all stage valids and rsp_valid on that edge; a request accepted on the same edge SHALL be discarded.
REQ-029 Pipeline stages SHALL be ordered by acceptance; responses SHALL never reorder, duplicate or drop except under flush or reset.

Reset
REQ-030 While rst is high: rsp_valid=0, rsp_data=0, all stage valids=0, and req_ready=1.
REQ-031 If CLEAR_ON_RST=1, every memory word SHALL read as zero after reset; if 0, memory contents SHALL be retained across reset.
REQ-032 rst asserted mid-fetch SHALL discard in-flight requests, with no response after release.
REQ-033 The first request SHALL be accepted on the first clk edge after rst deasserts.

Structure
REQ-034 A shared package im_pkg SHALL hold default DATA_W/ADDR_W/FETCH_N/RD_LAT constants and the fetch-bundle typedef (array of FETCH_N words).
REQ-035 The storage SHALL be a sub-module im_bank: one byte-enabled write port, FETCH_N combinational-address read ports with registered outputs.
REQ-036 Handshake, latency pipeline and flush logic SHALL reside in im_fetch_mem.

Verification
REQ-037 Bench scenario: with DATA_W=32, ADDR_W=4, FETCH_N=2, RD_LAT=1, load mem[i]=0x100+i for all 16 words, then request addr 3 -> next cycle rsp_valid=1, rsp_data={0x104,0x103}.
REQ-038 Bench scenario: request addr 15 -> rsp_data={0x100,0x10F} (wrap-around).
REQ-039 Bench scenario: RD_LAT=2, back-to-back requests 0,2,4 with rsp_ready held low 3 cycles after the first response -> req_ready=0 during the stall; responses {1,0},{3,2},{5,4} in order with none lost.
REQ-040 Bench scenario: ld_en with ld_addr=5, ld_be=4'b0010, ld_data=0xAABBCCDD, in the same cycle as a read of addr 5 -> response word0 0x105 (pre-write); a later read returns 0x0000CC05.
REQ-041 Bench scenario: flush asserted while two requests are in flight -> rsp_valid stays 0 and rsp_data=0 on every following cycle until the next new request.
REQ-042 Bench scenario: rst pulsed mid-stream with CLEAR_ON_RST=1 -> outputs zero immediately; a subsequent read of any address returns all zeros.
